// File: rtl/alu16_pkg.sv
// Shared types and widths for the alu16 driver and its WAIT timer.
package alu16_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 16;
    localparam int RES_W  = 17;

    // alu16.count value that marks a finished operation
    localparam logic [3:0] COUNT_TC = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu16_drv_timer.sv
// WAIT-state cycle counter: held at zero outside WAIT, saturates at TIMEOUT.
module alu16_drv_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != TO_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle whose closing edge brings the count to TIMEOUT.
    assign expire_o = en_i && (cnt_q == TO_LAST);

endmodule

// File: rtl/alu16_driver.sv
// Sequences one alu16 operation per request: strobe, wait for completion or
// timeout, then hold the registered result until the response is taken.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | req_ready high, waiting for a request transfer
//   ST_START | alu_on high for ON_CYCLES cycles
//   ST_WAIT  | watching alu_count for completion, timeout running
//   ST_RESP  | rsp_valid high until rsp_ready
module alu16_driver
    import alu16_pkg::*;
#(
    parameter int ON_CYCLES = 2,
    parameter int TIMEOUT   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OP_W-1:0]   req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              alu_on,
    output logic [DATA_W-1:0] alu_ina,
    output logic [DATA_W-1:0] alu_inb,
    output logic [OP_W-1:0]   alu_op,
    input  logic [RES_W-1:0]  alu_out,
    input  logic [3:0]        alu_count,
    output logic              busy
);

    localparam logic [2:0] ON_LAST = 3'(ON_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        on_cnt_q, on_cnt_d;
    logic              arm_q, arm_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              alu_on_q, alu_on_d;
    logic [DATA_W-1:0] alu_ina_q, alu_ina_d;
    logic [DATA_W-1:0] alu_inb_q, alu_inb_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              busy_q, busy_d;

    logic accept;
    logic capture;
    logic expire;

    assign accept  = (state_q == ST_IDLE) && req_valid;
    // arm_q masks a count of 15 left over from the previous operation
    assign capture = (state_q == ST_WAIT) && arm_q && (alu_count == COUNT_TC);

    alu16_drv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != ST_WAIT),
        .en_i     (state_q == ST_WAIT),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            on_cnt_q    <= 3'd0;
            arm_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            alu_on_q    <= 1'b0;
            alu_ina_q   <= '0;
            alu_inb_q   <= '0;
            alu_op_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            on_cnt_q    <= on_cnt_d;
            arm_q       <= arm_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            alu_on_q    <= alu_on_d;
            alu_ina_q   <= alu_ina_d;
            alu_inb_q   <= alu_inb_d;
            alu_op_q    <= alu_op_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid)              state_d = ST_START;
            ST_START: if (on_cnt_q == 3'd0)       state_d = ST_WAIT;
            ST_WAIT:  if (capture || expire)      state_d = ST_RESP;
            ST_RESP:  if (rsp_ready)              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Flag outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        alu_on_d    = (state_d == ST_START);
        rsp_valid_d = (state_d == ST_RESP);
        on_cnt_d    = on_cnt_q;
        arm_d       = arm_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        alu_ina_d   = alu_ina_q;
        alu_inb_d   = alu_inb_q;
        alu_op_d    = alu_op_q;

        if (accept) begin
            on_cnt_d  = ON_LAST;
            alu_ina_d = req_a;
            alu_inb_d = req_b;
            alu_op_d  = req_op;
        end else if ((state_q == ST_START) && (on_cnt_q != 3'd0)) begin
            on_cnt_d = on_cnt_q - 3'd1;
        end

        if (state_q != ST_WAIT) begin
            arm_d = 1'b0;
        end else if (alu_count != COUNT_TC) begin
            arm_d = 1'b1;
        end

        if (capture) begin
            rsp_data_d = alu_out;
            rsp_err_d  = 1'b0;
        end else if (expire) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign alu_on    = alu_on_q;
    assign alu_ina   = alu_ina_q;
    assign alu_inb   = alu_inb_q;
    assign alu_op    = alu_op_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu16_driver.sv
// Directed bench for alu16_driver with a behavioural alu16 stand-in that can
// be overridden to force alu_count / alu_out per scenario.
module tb_alu16_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [2:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [16:0] rsp_data;
    logic        rsp_err;
    logic        alu_on;
    logic [15:0] alu_ina;
    logic [15:0] alu_inb;
    logic [2:0]  alu_op;
    logic [16:0] alu_out;
    logic [3:0]  alu_count;
    logic        busy;

    logic        stub_mode = 1'b0;
    logic [3:0]  stub_count = 4'hF;
    logic [16:0] stub_out = '0;
    logic [3:0]  m_cnt = 4'hF;
    logic [16:0] m_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // alu16 stand-in: count restarts on the strobe, then climbs to 15 and holds.
    always @(posedge clk) begin
        if (alu_on === 1'b1) m_cnt <= 4'h0;
        else if (m_cnt != 4'hF) m_cnt <= m_cnt + 4'h1;
    end
    assign m_out     = (alu_op == 3'b000) ? ({1'b0, alu_ina} + {1'b0, alu_inb})
                                          : {1'b0, alu_ina & alu_inb};
    assign alu_count = stub_mode ? stub_count : m_cnt;
    assign alu_out   = stub_mode ? stub_out : m_out;

    alu16_driver #(.ON_CYCLES(2), .TIMEOUT(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .alu_on    (alu_on),
        .alu_ina   (alu_ina),
        .alu_inb   (alu_inb),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_count (alu_count),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        req_a = a;
        req_b = b;
        req_op = op;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // lat counts clock edges since the accepting edge (1 on entry).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_wait_entry();
        int n = 0;
        while (alu_on === 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1;
        tick();
        tick();
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (alu_on !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_on_busy: got on=%b busy=%b want 0 0", alu_on, busy); end
        checks++; if (rsp_data !== 17'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got data=%h err=%b want 0 0", rsp_data, rsp_err); end
        checks++; if ({alu_ina, alu_inb, alu_op} !== 35'h0) begin errors++; $display("FAIL reset_operands: got %h %h %h want 0", alu_ina, alu_inb, alu_op); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int lat = 1;
        int on_n = 0;
        int unstable = 0;
        int extra = 0;
        stub_mode = 1'b0;
        rsp_ready = 1'b0;
        send(16'h7002, 16'h0003, 3'b000);
        while (rsp_valid !== 1'b1 && lat < 100) begin
            if (alu_on === 1'b1) on_n++;
            if (alu_ina !== 16'h7002 || alu_inb !== 16'h0003 || alu_op !== 3'b000) unstable++;
            tick();
            lat++;
        end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: no response within budget"); end
        checks++; if (lat != 19) begin errors++; $display("FAIL add_latency: got %0d want 19", lat); end
        checks++; if (on_n != 2) begin errors++; $display("FAIL add_on_cycles: got %0d want 2", on_n); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL add_operands_stable: %0d unstable cycles want 0", unstable); end
        checks++; if (rsp_data !== 17'h07005) begin errors++; $display("FAIL add_data: got %h want 07005", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", rsp_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL add_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) extra++;
            tick();
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL add_single_rsp: %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_carry();
        int lat;
        send(16'hFFFF, 16'h0001, 3'b000);
        wait_rsp(lat);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 17'h10000) begin errors++; $display("FAIL carry_data: got valid=%b data=%h want 1 10000", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        int total;
        rsp_ready = 1'b1;
        send(16'h0100, 16'h0200, 3'b000);
        wait_rsp(lat);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 17'h00300) begin errors++; $display("FAIL b2b_first_data: got valid=%b data=%h want 1 00300", rsp_valid, rsp_data); end
        tick();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_ready_next: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
        send(16'h8000, 16'h8000, 3'b000);
        total = lat + 2;
        checks++; if (alu_on !== 1'b1 || alu_ina !== 16'h8000) begin errors++; $display("FAIL b2b_second_accept: got on=%b ina=%h want 1 8000", alu_on, alu_ina); end
        checks++; if (total != 21) begin errors++; $display("FAIL b2b_period: got %0d want 21", total); end
        wait_rsp(lat);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 17'h10000 || rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_second_data: got valid=%b data=%h err=%b want 1 10000 0", rsp_valid, rsp_data, rsp_err); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        int extra = 0;
        send(16'h1234, 16'h1111, 3'b000);
        wait_rsp(lat);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 17'h02345) begin errors++; $display("FAIL bp_data: got valid=%b data=%h want 1 02345", rsp_valid, rsp_data); end
        req_a = 16'hFFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 17'h02345 || rsp_err !== 1'b0 ||
                req_ready !== 1'b0 || alu_ina !== 16'h1234) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
        for (int i = 0; i < 25; i++) begin
            if (rsp_valid !== 1'b0 || alu_on !== 1'b0) extra++;
            tick();
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL bp_no_buffer: %0d active cycles want 0", extra); end
    endtask

    task automatic test_timeout();
        int w = 0;
        stub_mode = 1'b1;
        stub_count = 4'h3;
        stub_out = 17'h1FFFF;
        send(16'hAAAA, 16'h5555, 3'b000);
        wait_wait_entry();
        while (rsp_valid !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        checks++; if (w != 32) begin errors++; $display("FAIL timeout_latency: got %0d want 32", w); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 17'h0) begin errors++; $display("FAIL timeout_rsp: got err=%b data=%h want 1 00000", rsp_err, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        stub_mode = 1'b0;
    endtask

    task automatic test_stale();
        int early = 0;
        stub_mode = 1'b1;
        stub_count = 4'hF;
        stub_out = 17'h1ABCD;
        send(16'h0001, 16'h0002, 3'b000);
        wait_wait_entry();
        for (int k = 0; k < 19; k++) begin
            stub_count = (k < 3) ? 4'hF : 4'(k - 3);
            if (rsp_valid !== 1'b0) early++;
            tick();
        end
        checks++; if (early != 0) begin errors++; $display("FAIL stale_early_capture: %0d early cycles want 0", early); end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 17'h1ABCD || rsp_err !== 1'b0) begin errors++; $display("FAIL stale_capture: got valid=%b data=%h err=%b want 1 1abcd 0", rsp_valid, rsp_data, rsp_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        stub_mode = 1'b0;
    endtask

    task automatic test_midreset();
        int lat;
        int extra = 0;
        send(16'h4000, 16'h0001, 3'b000);
        wait_wait_entry();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_on !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_state: got ready=%b valid=%b on=%b busy=%b want 1 0 0 0", req_ready, rsp_valid, alu_on, busy); end
        for (int i = 0; i < 25; i++) begin
            if (rsp_valid !== 1'b0) extra++;
            tick();
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL midreset_no_rsp: %0d valid cycles want 0", extra); end
        send(16'h0005, 16'h000A, 3'b000);
        wait_rsp(lat);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 17'h0000F || lat != 19) begin errors++; $display("FAIL midreset_followup: got valid=%b data=%h lat=%0d want 1 0000f 19", rsp_valid, rsp_data, lat); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_stale();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
